// File: rtl/raptor64_fetch_pc_if.sv
// Raptor64 IF next-PC stage bus: fetch control, EX branch resolution,
// mispredict redirect, and the PC/prediction/counter outputs.
interface raptor64_fetch_pc_if;
  logic        i_advance;
  logic        i_predict_taken;
  logic        i_btb_flush;
  logic        i_x_update;
  logic [63:0] i_xpc;
  logic [63:0] i_xtarget;
  logic        i_xtaken;
  logic        i_x_mispredict;
  logic [63:0] i_x_fix_pc;
  logic [63:0] o_pc;
  logic        o_ipredicted;
  logic [63:0] o_ipred_target;
  logic [31:0] o_nbranch;
  logic [31:0] o_nmispredict;

  modport master (
    output i_advance, i_predict_taken, i_btb_flush, i_x_update, i_xpc,
           i_xtarget, i_xtaken, i_x_mispredict, i_x_fix_pc,
    input  o_pc, o_ipredicted, o_ipred_target, o_nbranch, o_nmispredict
  );

  modport slave (
    input  i_advance, i_predict_taken, i_btb_flush, i_x_update, i_xpc,
           i_xtarget, i_xtaken, i_x_mispredict, i_x_fix_pc,
    output o_pc, o_ipredicted, o_ipred_target, o_nbranch, o_nmispredict
  );
endinterface

// File: rtl/raptor64_fetch_pc.sv
// Raptor64 instruction-fetch next-PC stage: program counter, 64-entry
// direct-mapped BTB (index pc[7:2], tag pc[63:8]) and branch/mispredict
// performance counters.
module raptor64_fetch_pc #(
  parameter logic [63:0] RESET_VECTOR = 64'h0000_0000_FFFF_FFF0
) (
  input logic                  clk,
  input logic                  rst,
  raptor64_fetch_pc_if.slave   bus
);

  logic [63:0] r_pc;
  logic [63:0] r_btb_valid;
  logic [55:0] r_btb_tag    [0:63];
  logic [61:0] r_btb_target [0:63];
  logic [31:0] r_nbranch;
  logic [31:0] r_nmispredict;

  logic [5:0]  w_idx;
  logic        w_hit;
  logic        w_ipredicted;
  logic [63:0] w_ipred_target;
  logic [5:0]  w_wr_idx;
  logic        w_btb_wr;
  logic        w_unused;

  // Byte-offset bits of the branch address and target carry no information.
  assign w_unused = ^{bus.i_xpc[1:0], bus.i_xtarget[1:0]};

  assign w_idx          = r_pc[7:2];
  assign w_hit          = r_btb_valid[w_idx] && (r_btb_tag[w_idx] == r_pc[63:8]);
  assign w_ipredicted   = w_hit && bus.i_predict_taken;
  assign w_ipred_target = {r_btb_target[w_idx], 2'b00};

  assign w_wr_idx = bus.i_xpc[7:2];
  // A flush in the same cycle wins, so the write is dropped entirely.
  assign w_btb_wr = bus.i_x_update && bus.i_xtaken && !bus.i_btb_flush;

  assign bus.o_pc           = r_pc;
  assign bus.o_ipredicted   = w_ipredicted;
  assign bus.o_ipred_target = w_ipred_target;
  assign bus.o_nbranch      = r_nbranch;
  assign bus.o_nmispredict  = r_nmispredict;

  // Next-PC selection: reset, redirect, predicted target, sequential, hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_VECTOR;
    end else if (bus.i_x_mispredict) begin
      r_pc <= {bus.i_x_fix_pc[63:2], 2'b00};
    end else if (bus.i_advance && w_ipredicted) begin
      r_pc <= w_ipred_target;
    end else if (bus.i_advance) begin
      r_pc <= r_pc + 64'd4;
    end
  end

  // BTB valid bits live in flops so reset and flush clear them in one cycle.
  always_ff @(posedge clk) begin
    if (rst || bus.i_btb_flush) begin
      r_btb_valid <= '0;
    end else if (w_btb_wr) begin
      r_btb_valid[w_wr_idx] <= 1'b1;
    end
  end

  // BTB tag/target payload; no reset needed since valid gates every use.
  always_ff @(posedge clk) begin
    if (w_btb_wr) begin
      r_btb_tag[w_wr_idx]    <= bus.i_xpc[63:8];
      r_btb_target[w_wr_idx] <= bus.i_xtarget[63:2];
    end
  end

  // Resolved-branch counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_nbranch <= '0;
    end else if (bus.i_x_update && (r_nbranch != 32'hFFFF_FFFF)) begin
      r_nbranch <= r_nbranch + 32'd1;
    end
  end

  // Mispredict counter; redirects without a resolved branch are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_nmispredict <= '0;
    end else if (bus.i_x_update && bus.i_x_mispredict &&
                 (r_nmispredict != 32'hFFFF_FFFF)) begin
      r_nmispredict <= r_nmispredict + 32'd1;
    end
  end

endmodule

// File: tb/tb_raptor64_fetch_pc.sv
// Directed bench for raptor64_fetch_pc with hand-computed expectations.
module tb_raptor64_fetch_pc;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  raptor64_fetch_pc_if bus ();

  raptor64_fetch_pc #(.RESET_VECTOR(64'h0000_0000_FFFF_FFF0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_advance       = 1'b0;
    bus.i_predict_taken = 1'b0;
    bus.i_btb_flush     = 1'b0;
    bus.i_x_update      = 1'b0;
    bus.i_xpc           = 64'd0;
    bus.i_xtarget       = 64'd0;
    bus.i_xtaken        = 1'b0;
    bus.i_x_mispredict  = 1'b0;
    bus.i_x_fix_pc      = 64'd0;
  endtask

  task automatic redirect(input logic [63:0] a);
    bus.i_x_mispredict = 1'b1;
    bus.i_x_fix_pc     = a;
    step();
    bus.i_x_mispredict = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_checks++;
    if (bus.o_pc !== 64'h0000_0000_FFFF_FFF0) $display("FAIL reset_pc got %h exp %h", bus.o_pc, 64'h0000_0000_FFFF_FFF0);
    else n_pass++;
    n_checks++;
    if (bus.o_ipredicted !== 1'b0) $display("FAIL reset_ipredicted got %b exp 0", bus.o_ipredicted);
    else n_pass++;
    n_checks++;
    if (bus.o_nbranch !== 32'd0) $display("FAIL reset_nbranch got %h exp 0", bus.o_nbranch);
    else n_pass++;
    n_checks++;
    if (bus.o_nmispredict !== 32'd0) $display("FAIL reset_nmispredict got %h exp 0", bus.o_nmispredict);
    else n_pass++;
  endtask

  task automatic test_sequential();
    logic [63:0] exp_pc [3];
    exp_pc[0] = 64'h0000_0000_FFFF_FFF4;
    exp_pc[1] = 64'h0000_0000_FFFF_FFF8;
    exp_pc[2] = 64'h0000_0000_FFFF_FFFC;
    bus.i_advance = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (bus.o_pc !== exp_pc[i]) $display("FAIL seq_pc%0d got %h exp %h", i, bus.o_pc, exp_pc[i]);
      else n_pass++;
    end
    bus.i_advance = 1'b0;
    step();
    n_checks++;
    if (bus.o_pc !== 64'h0000_0000_FFFF_FFFC) $display("FAIL hold_pc got %h exp %h", bus.o_pc, 64'h0000_0000_FFFF_FFFC);
    else n_pass++;
    redirect(64'hFFFF_FFFF_FFFF_FFFE);
    n_checks++;
    if (bus.o_pc !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL top_pc got %h exp %h", bus.o_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    else n_pass++;
    bus.i_advance = 1'b1;
    step();
    bus.i_advance = 1'b0;
    n_checks++;
    if (bus.o_pc !== 64'd0) $display("FAIL wrap_pc got %h exp 0", bus.o_pc);
    else n_pass++;
  endtask

  task automatic test_btb_hit();
    redirect(64'h1000);
    bus.i_x_update = 1'b1;
    bus.i_xpc      = 64'h1010;
    bus.i_xtaken   = 1'b1;
    bus.i_xtarget  = 64'h2003;
    bus.i_advance  = 1'b1;
    step();
    bus.i_x_update = 1'b0;
    bus.i_xtaken   = 1'b0;
    n_checks++;
    if (bus.o_nbranch !== 32'd1) $display("FAIL hit_nbranch got %h exp 1", bus.o_nbranch);
    else n_pass++;
    step();
    step();
    step();
    n_checks++;
    if (bus.o_pc !== 64'h1010) $display("FAIL hit_reach got %h exp %h", bus.o_pc, 64'h1010);
    else n_pass++;
    bus.i_predict_taken = 1'b1;
    #1;
    n_checks++;
    if (bus.o_ipredicted !== 1'b1) $display("FAIL hit_ipredicted got %b exp 1", bus.o_ipredicted);
    else n_pass++;
    n_checks++;
    if (bus.o_ipred_target !== 64'h2000) $display("FAIL hit_target got %h exp %h", bus.o_ipred_target, 64'h2000);
    else n_pass++;
    step();
    n_checks++;
    if (bus.o_pc !== 64'h2000) $display("FAIL hit_next_pc got %h exp %h", bus.o_pc, 64'h2000);
    else n_pass++;
    n_checks++;
    if (bus.o_ipredicted !== 1'b0) $display("FAIL miss_at_target got %b exp 0", bus.o_ipredicted);
    else n_pass++;
    bus.i_advance       = 1'b0;
    bus.i_predict_taken = 1'b0;
  endtask

  task automatic test_not_taken_pred();
    redirect(64'h1010);
    bus.i_advance       = 1'b1;
    bus.i_predict_taken = 1'b0;
    #1;
    n_checks++;
    if (bus.o_ipredicted !== 1'b0) $display("FAIL nt_ipredicted got %b exp 0", bus.o_ipredicted);
    else n_pass++;
    step();
    n_checks++;
    if (bus.o_pc !== 64'h1014) $display("FAIL nt_next_pc got %h exp %h", bus.o_pc, 64'h1014);
    else n_pass++;
    bus.i_advance = 1'b0;
  endtask

  task automatic test_alias();
    redirect(64'h5010);
    bus.i_advance       = 1'b1;
    bus.i_predict_taken = 1'b1;
    #1;
    n_checks++;
    if (bus.o_ipredicted !== 1'b0) $display("FAIL alias_ipredicted got %b exp 0", bus.o_ipredicted);
    else n_pass++;
    step();
    n_checks++;
    if (bus.o_pc !== 64'h5014) $display("FAIL alias_next_pc got %h exp %h", bus.o_pc, 64'h5014);
    else n_pass++;
    bus.i_advance       = 1'b0;
    bus.i_predict_taken = 1'b0;
  endtask

  task automatic test_no_bypass();
    redirect(64'h1020);
    bus.i_x_update      = 1'b1;
    bus.i_xpc           = 64'h1020;
    bus.i_xtaken        = 1'b1;
    bus.i_xtarget       = 64'h3000;
    bus.i_predict_taken = 1'b1;
    bus.i_advance       = 1'b1;
    #1;
    n_checks++;
    if (bus.o_ipredicted !== 1'b0) $display("FAIL nobyp_ipredicted got %b exp 0", bus.o_ipredicted);
    else n_pass++;
    step();
    bus.i_x_update = 1'b0;
    bus.i_xtaken   = 1'b0;
    bus.i_advance  = 1'b0;
    n_checks++;
    if (bus.o_pc !== 64'h1024) $display("FAIL nobyp_next_pc got %h exp %h", bus.o_pc, 64'h1024);
    else n_pass++;
    redirect(64'h1020);
    #1;
    n_checks++;
    if (bus.o_ipredicted !== 1'b1) $display("FAIL nobyp_later_hit got %b exp 1", bus.o_ipredicted);
    else n_pass++;
    n_checks++;
    if (bus.o_ipred_target !== 64'h3000) $display("FAIL nobyp_target got %h exp %h", bus.o_ipred_target, 64'h3000);
    else n_pass++;
    bus.i_predict_taken = 1'b0;
  endtask

  task automatic test_not_taken_update();
    bus.i_x_update = 1'b1;
    bus.i_xpc      = 64'h1030;
    bus.i_xtaken   = 1'b0;
    bus.i_xtarget  = 64'h4000;
    step();
    bus.i_x_update = 1'b0;
    n_checks++;
    if (bus.o_nbranch !== 32'd3) $display("FAIL ntu_nbranch got %h exp 3", bus.o_nbranch);
    else n_pass++;
    redirect(64'h1030);
    bus.i_predict_taken = 1'b1;
    #1;
    n_checks++;
    if (bus.o_ipredicted !== 1'b0) $display("FAIL ntu_ipredicted got %b exp 0", bus.o_ipredicted);
    else n_pass++;
    bus.i_predict_taken = 1'b0;
  endtask

  task automatic test_mispredict();
    bus.i_advance      = 1'b0;
    bus.i_x_update     = 1'b1;
    bus.i_xpc          = 64'h1100;
    bus.i_xtaken       = 1'b0;
    bus.i_x_mispredict = 1'b1;
    bus.i_x_fix_pc     = 64'h3003;
    step();
    bus.i_x_update     = 1'b0;
    bus.i_x_mispredict = 1'b0;
    n_checks++;
    if (bus.o_pc !== 64'h3000) $display("FAIL mp_pc got %h exp %h", bus.o_pc, 64'h3000);
    else n_pass++;
    n_checks++;
    if (bus.o_nbranch !== 32'd4) $display("FAIL mp_nbranch got %h exp 4", bus.o_nbranch);
    else n_pass++;
    n_checks++;
    if (bus.o_nmispredict !== 32'd1) $display("FAIL mp_nmispredict got %h exp 1", bus.o_nmispredict);
    else n_pass++;
    redirect(64'h3103);
    n_checks++;
    if (bus.o_pc !== 64'h3100) $display("FAIL trap_pc got %h exp %h", bus.o_pc, 64'h3100);
    else n_pass++;
    n_checks++;
    if (bus.o_nbranch !== 32'd4) $display("FAIL trap_nbranch got %h exp 4", bus.o_nbranch);
    else n_pass++;
    n_checks++;
    if (bus.o_nmispredict !== 32'd1) $display("FAIL trap_nmispredict got %h exp 1", bus.o_nmispredict);
    else n_pass++;
    redirect(64'h1010);
    bus.i_predict_taken = 1'b1;
    bus.i_advance       = 1'b1;
    #1;
    n_checks++;
    if (bus.o_ipredicted !== 1'b1) $display("FAIL prio_ipredicted got %b exp 1", bus.o_ipredicted);
    else n_pass++;
    bus.i_x_mispredict = 1'b1;
    bus.i_x_fix_pc     = 64'h7000;
    step();
    bus.i_x_mispredict  = 1'b0;
    bus.i_predict_taken = 1'b0;
    bus.i_advance       = 1'b0;
    n_checks++;
    if (bus.o_pc !== 64'h7000) $display("FAIL prio_pc got %h exp %h", bus.o_pc, 64'h7000);
    else n_pass++;
  endtask

  task automatic test_flush();
    bus.i_x_update  = 1'b1;
    bus.i_xpc       = 64'h1040;
    bus.i_xtaken    = 1'b1;
    bus.i_xtarget   = 64'h6000;
    bus.i_btb_flush = 1'b1;
    step();
    bus.i_x_update  = 1'b0;
    bus.i_xtaken    = 1'b0;
    bus.i_btb_flush = 1'b0;
    n_checks++;
    if (bus.o_nbranch !== 32'd5) $display("FAIL flush_nbranch got %h exp 5", bus.o_nbranch);
    else n_pass++;
    redirect(64'h1040);
    bus.i_predict_taken = 1'b1;
    #1;
    n_checks++;
    if (bus.o_ipredicted !== 1'b0) $display("FAIL flush_dropped_write got %b exp 0", bus.o_ipredicted);
    else n_pass++;
    redirect(64'h1010);
    #1;
    n_checks++;
    if (bus.o_ipredicted !== 1'b0) $display("FAIL flush_old_entry got %b exp 0", bus.o_ipredicted);
    else n_pass++;
    bus.i_predict_taken = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.i_x_update = 1'b1;
    bus.i_xpc      = 64'h1050;
    bus.i_xtaken   = 1'b1;
    bus.i_xtarget  = 64'h8000;
    step();
    n_checks++;
    if (bus.o_nbranch !== 32'd6) $display("FAIL rm_pre_nbranch got %h exp 6", bus.o_nbranch);
    else n_pass++;
    rst                 = 1'b1;
    bus.i_advance       = 1'b1;
    bus.i_x_mispredict  = 1'b1;
    bus.i_x_fix_pc      = 64'h9000;
    bus.i_predict_taken = 1'b1;
    step();
    rst = 1'b0;
    clear_inputs();
    n_checks++;
    if (bus.o_pc !== 64'h0000_0000_FFFF_FFF0) $display("FAIL rm_pc got %h exp %h", bus.o_pc, 64'h0000_0000_FFFF_FFF0);
    else n_pass++;
    n_checks++;
    if (bus.o_nbranch !== 32'd0) $display("FAIL rm_nbranch got %h exp 0", bus.o_nbranch);
    else n_pass++;
    n_checks++;
    if (bus.o_nmispredict !== 32'd0) $display("FAIL rm_nmispredict got %h exp 0", bus.o_nmispredict);
    else n_pass++;
    redirect(64'h1050);
    bus.i_predict_taken = 1'b1;
    #1;
    n_checks++;
    if (bus.o_ipredicted !== 1'b0) $display("FAIL rm_btb_cleared got %b exp 0", bus.o_ipredicted);
    else n_pass++;
    bus.i_predict_taken = 1'b0;
  endtask

  task automatic test_saturation();
    force dut.r_nbranch     = 32'hFFFF_FFFE;
    force dut.r_nmispredict = 32'hFFFF_FFFE;
    #1;
    release dut.r_nbranch;
    release dut.r_nmispredict;
    bus.i_x_update     = 1'b1;
    bus.i_x_mispredict = 1'b1;
    bus.i_x_fix_pc     = 64'h0;
    step();
    n_checks++;
    if (bus.o_nbranch !== 32'hFFFF_FFFF) $display("FAIL sat1_nbranch got %h exp ffffffff", bus.o_nbranch);
    else n_pass++;
    n_checks++;
    if (bus.o_nmispredict !== 32'hFFFF_FFFF) $display("FAIL sat1_nmispredict got %h exp ffffffff", bus.o_nmispredict);
    else n_pass++;
    step();
    step();
    clear_inputs();
    n_checks++;
    if (bus.o_nbranch !== 32'hFFFF_FFFF) $display("FAIL sat3_nbranch got %h exp ffffffff", bus.o_nbranch);
    else n_pass++;
    n_checks++;
    if (bus.o_nmispredict !== 32'hFFFF_FFFF) $display("FAIL sat3_nmispredict got %h exp ffffffff", bus.o_nmispredict);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    clear_inputs();
    test_reset();
    test_sequential();
    test_btb_hit();
    test_not_taken_pred();
    test_alias();
    test_no_bypass();
    test_not_taken_update();
    test_mispredict();
    test_flush();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/raptor64_fetch_pc.md
Name: raptor64_fetch_pc

Overview:
- Instruction-fetch (IF) next-PC stage of the Raptor64 pipeline.
- Owns the program counter and a 64-entry direct-mapped branch target buffer (BTB).
- Consumes the combinational `predict_taken` bit from the branch-history predictor, which is indexed by this block's `pc`, and steers fetch to the predicted target.
- Accepts branch-resolution and mispredict-redirect information from the EX stage and keeps branch/mispredict performance counters.

Parameters:
- RESET_VECTOR, 64'h0000_0000_FFFF_FFF0, PC value loaded on reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- advanceI  in  1  IF stage advances this cycle
- predict_taken  in  1  direction prediction for current `pc` (combinational from predictor)
- btb_flush  in  1  invalidate all BTB entries
- x_update  in  1  EX resolved a branch and advanceX is high (single-cycle pulse)
- xpc  in  64  PC of the resolved branch
- xtarget  in  64  resolved branch target
- xtaken  in  1  resolved branch was taken
- x_mispredict  in  1  EX detected a wrong fetch path; redirect required
- x_fix_pc  in  64  correct fetch address on mispredict
- pc  out  64  current fetch address (registered)
- ipredicted  out  1  current `pc` predicted taken with a BTB hit (combinational)
- ipred_target  out  64  BTB target for current `pc` (valid when `ipredicted`)
- nbranch  out  32  resolved-branch count
- nmispredict  out  32  mispredict count

Behaviour:
- Reset is synchronous, active-high: rst on clk, sampled at the rising edge. On reset:
  - `pc` = RESET_VECTOR.
  - All 64 BTB valid bits = 0.
  - `nbranch` = 0, `nmispredict` = 0.
  - `ipredicted` = 0 from the first cycle after reset, because no entry is valid.
- BTB storage:
  - 64 entries, each holding valid, tag[55:0] and target[63:2].
  - Index = address[7:2]; tag = address[63:8].
  - The valid bits are a flop vector so they can be cleared in one cycle; tag and target may be RAM.
- BTB lookup is combinational on `pc`:
  - hit = valid[pc[7:2]] && tag == pc[63:8].
  - `ipredicted` = hit && predict_taken.
  - `ipred_target` = {target, 2'b00}.
- BTB write, at the clock edge when x_update && xtaken:
  - entry[xpc[7:2]] gets valid=1, tag=xpc[63:8], target=xtarget[63:2].
  - xtarget[1:0] is ignored.
  - When x_update && !xtaken, the BTB is unchanged.
- No read bypass: a write and a lookup to the same index in the same cycle give the lookup the pre-write contents.
- btb_flush clears all valid bits at the next edge. It has priority over a same-cycle BTB write; that write is dropped.
- Next-PC priority, evaluated at each rising edge:
  1. rst → RESET_VECTOR.
  2. x_mispredict → x_fix_pc with bits [1:0] forced to 0. Applies regardless of advanceI.
  3. advanceI && ipredicted → ipred_target.
  4. advanceI → pc + 4, wrapping modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC → 0).
  5. Otherwise hold `pc`.
- Latency:
  - A redirect takes effect on `pc` one cycle after x_mispredict is sampled.
  - A predicted-taken `pc` is followed by its target in the next cycle (zero-bubble taken branch).
- Counters:
  - `nbranch` increments by 1 when x_update is high.
  - `nmispredict` increments by 1 when x_update && x_mispredict.
  - Both saturate at 32'hFFFF_FFFF and never wrap.
  - x_mispredict without x_update (e.g. trap redirect) redirects `pc` but does not count.
- Simultaneous events:
  - x_mispredict together with x_update: the BTB write and the counter updates both occur, and `pc` takes x_fix_pc.
  - Reset asserted mid-operation overrides every other input in that cycle.

Test Plan:
- Reset → `pc`=64'h0000_0000_FFFF_FFF0, `ipredicted`=0, counters=0. Then advanceI=1 for 3 cycles → `pc` steps …FFF4, …FFF8, …FFFC.
- `pc`=64'h1000 region. Pulse x_update with xpc=64'h1010, xtaken=1, xtarget=64'h2000; later fetch reaches 64'h1010 with predict_taken=1, advanceI=1 → `ipredicted`=1, `ipred_target`=64'h2000, next `pc`=64'h2000.
- Same BTB entry, predict_taken=0 at 64'h1010 → `ipredicted`=0, next `pc`=64'h1014.
- Aliasing: fetch 64'h5010, which has the same index as 64'h1010 but a different tag → no hit, next `pc`=64'h5014.
- x_mispredict=1, x_fix_pc=64'h3003, advanceI=0 → next `pc`=64'h3000. If x_update is also high, `nbranch` and `nmispredict` each increment by 1.
- btb_flush in the same cycle as a taken write → all entries invalid; a subsequent fetch of the written xpc gives `ipredicted`=0.
- Preload `nbranch`=32'hFFFF_FFFE via 2^32−2 pulses (or a force), then pulse x_update 3 times → `nbranch` stays at 32'hFFFF_FFFF.
